// File: rtl/cmd_decoder_pkg.sv
// Shared constants, frame offsets and state encoding for the Ethernet command decoder.
package cmd_decoder_pkg;

   localparam logic [15:0] OP_BANK_CC = 16'h4343;
   localparam logic [15:0] OP_BANK_FF = 16'h4646;
   localparam logic [15:0] OP_WR      = 16'h5757;
   localparam logic [15:0] OP_RD      = 16'h5252;

   localparam logic [5:0] OFF_ID     = 6'd14;
   localparam logic [5:0] OFF_OPCODE = 6'd16;
   localparam logic [5:0] OFF_ADDR   = 6'd20;
   localparam logic [5:0] OFF_DATA   = 6'd24;
   localparam logic [5:0] OFF_DRAIN  = 6'd28;

   localparam logic [5:0]  REPLY_LEN     = 6'd60;
   localparam logic [15:0] REPLY_HDR_LEN = 16'h000e;

   localparam logic [7:0] STATUS_OK  = 8'h00;
   localparam logic [7:0] STATUS_ERR = 8'h01;

   typedef enum logic [2:0] {
      RX_HDR,
      RX_CMD,
      RX_DRAIN,
      EXEC,
      TX,
      DROP
   } state_t;

endpackage

// File: rtl/cmd_reply_tx.sv
// Serializes the fixed 60-byte reply frame onto an 8-bit AXI-Stream.
// Fields must stay stable from i_start until o_done.
module cmd_reply_tx
   import cmd_decoder_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [47:0] i_dst_mac,
   input  logic [47:0] i_src_mac,
   input  logic [7:0]  i_id,
   input  logic [7:0]  i_status,
   input  logic [31:0] i_opcode,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_data,
   output logic [7:0]  o_tdata,
   output logic        o_tvalid,
   output logic        o_tlast,
   input  logic        i_tready,
   output logic        o_done
);

   logic [5:0] r_idx;
   logic [7:0] r_tdata;
   logic       r_tvalid;
   logic       r_tlast;
   logic [5:0] w_sel_idx;
   logic [5:0] w_src_rel;
   logic [7:0] w_byte;

   // Index of the byte being loaded into the output register this cycle.
   assign w_sel_idx = i_start ? 6'd0 : r_idx + 6'd1;
   assign w_src_rel = w_sel_idx - 6'd6;

   always_comb begin
      w_byte = 8'h00;
      if (w_sel_idx < 6'd6)
         w_byte = 8'(i_dst_mac >> {3'd5 - w_sel_idx[2:0], 3'b000});
      else if (w_sel_idx < 6'd12)
         w_byte = 8'(i_src_mac >> {3'd5 - w_src_rel[2:0], 3'b000});
      else if (w_sel_idx == 6'd12)
         w_byte = REPLY_HDR_LEN[15:8];
      else if (w_sel_idx == 6'd13)
         w_byte = REPLY_HDR_LEN[7:0];
      else if (w_sel_idx == OFF_ID)
         w_byte = i_id;
      else if (w_sel_idx == OFF_ID + 6'd1)
         w_byte = i_status;
      else if (w_sel_idx < OFF_ADDR)
         w_byte = 8'(i_opcode >> {2'd3 - w_sel_idx[1:0], 3'b000});
      else if (w_sel_idx < OFF_DATA)
         w_byte = 8'(i_addr >> {w_sel_idx[1:0], 3'b000});
      else if (w_sel_idx < OFF_DRAIN)
         w_byte = 8'(i_data >> {w_sel_idx[1:0], 3'b000});
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idx    <= '0;
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
      end else if (i_start) begin
         r_idx    <= '0;
         r_tdata  <= w_byte;
         r_tvalid <= 1'b1;
         r_tlast  <= 1'b0;
      end else if (r_tvalid && i_tready) begin
         if (r_tlast) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
         end else begin
            r_idx   <= w_sel_idx;
            r_tdata <= w_byte;
            r_tlast <= (w_sel_idx == REPLY_LEN - 6'd1);
         end
      end
   end

   assign o_tdata  = r_tdata;
   assign o_tvalid = r_tvalid;
   assign o_tlast  = r_tlast;
   assign o_done   = r_tvalid && r_tlast && i_tready;

endmodule

// File: rtl/cmd_decoder.sv
// Parses host command frames, executes reads/writes on the CTRL and FMC
// register banks and hands the reply fields to the serializer.
module cmd_decoder
#(
   parameter logic [47:0] FPGA_MAC_ADDR = 48'h5a0102030405
)
(
   input  logic       gtx_clk_bufg,
   input  logic       gtx_reset,
   input  logic [7:0] gpio_dip_sw,
   output logic [7:0] gpio_led,
   input  logic [7:0] rx_axis_tdata,
   input  logic       rx_axis_tvalid,
   input  logic       rx_axis_tlast,
   output logic       rx_axis_tready,
   output logic [7:0] tx_axis_tdata,
   output logic       tx_axis_tvalid,
   output logic       tx_axis_tlast,
   input  logic       tx_axis_tready,
   output logic       frame_error
);
   import cmd_decoder_pkg::*;

   state_t      r_state, w_state_next;
   logic [5:0]  r_offset;
   logic        r_match_fpga, r_match_bcast;
   logic [47:0] r_src;
   logic [7:0]  r_id;
   logic [31:0] r_opcode, r_addr, r_data;
   logic [7:0]  r_status;
   logic [31:0] r_reply_data;
   logic        r_frame_error;
   logic [31:0] r_ctrl [8];
   logic [31:0] r_fmc  [8];

   logic        w_beat, w_exec, w_trunc, w_start, w_tx_done;
   logic [7:0]  w_mac_byte;
   logic        w_m_fpga, w_m_bcast, w_dst_ok;
   logic [31:0] w_data_eff, w_rd_val;
   logic        w_bank_ctrl, w_bank_fmc, w_op_wr, w_op_rd, w_cmd_ok;
   logic [2:0]  w_idx;
   logic [7:0]  w_wr_ctrl, w_wr_fmc;

   assign rx_axis_tready = (r_state != EXEC) && (r_state != TX);
   assign w_beat         = rx_axis_tvalid && rx_axis_tready;

   // Destination match is tracked byte by byte so the verdict is ready on byte 5.
   assign w_mac_byte = 8'(FPGA_MAC_ADDR >> {3'd5 - r_offset[2:0], 3'b000});
   assign w_m_fpga   = (r_offset == 6'd0 || r_match_fpga)  && (rx_axis_tdata == w_mac_byte);
   assign w_m_bcast  = (r_offset == 6'd0 || r_match_bcast) && (rx_axis_tdata == 8'hff);
   assign w_dst_ok   = (r_offset > 6'd5) || w_m_fpga || w_m_bcast;

   // When tlast lands on byte 27 the top data byte is still on the bus.
   assign w_data_eff  = (r_state == RX_CMD) ? {rx_axis_tdata, r_data[31:8]} : r_data;
   assign w_bank_ctrl = (r_opcode[31:16] == OP_BANK_CC);
   assign w_bank_fmc  = (r_opcode[31:16] == OP_BANK_FF);
   assign w_op_wr     = (r_opcode[15:0] == OP_WR);
   assign w_op_rd     = (r_opcode[15:0] == OP_RD);
   assign w_cmd_ok    = (w_bank_ctrl || w_bank_fmc) && (w_op_wr || w_op_rd) && (r_addr[31:3] == 29'd0);
   assign w_idx       = r_addr[2:0];
   assign w_rd_val    = w_bank_ctrl ? ((w_idx == 3'd7) ? {24'd0, gpio_dip_sw} : r_ctrl[w_idx])
                                    : r_fmc[w_idx];

   for (genvar gi = 0; gi < 8; gi++) begin : g_wr_en
      assign w_wr_ctrl[gi] = w_exec && w_cmd_ok && w_op_wr && w_bank_ctrl && (w_idx == 3'(gi)) && (gi != 7);
      assign w_wr_fmc[gi]  = w_exec && w_cmd_ok && w_op_wr && w_bank_fmc  && (w_idx == 3'(gi));
   end

   always_comb begin
      w_state_next = r_state;
      w_exec       = 1'b0;
      w_trunc      = 1'b0;
      w_start      = 1'b0;
      case (r_state)
         RX_HDR: if (w_beat) begin
            if (rx_axis_tlast) begin
               w_trunc      = w_dst_ok;
               w_state_next = RX_HDR;
            end else if (r_offset == 6'd5 && !w_dst_ok)
               w_state_next = DROP;
            else if (r_offset == OFF_ID - 6'd1)
               w_state_next = RX_CMD;
         end
         RX_CMD: if (w_beat) begin
            if (rx_axis_tlast) begin
               if (r_offset == OFF_DRAIN - 6'd1) begin
                  w_exec       = 1'b1;
                  w_state_next = EXEC;
               end else begin
                  w_trunc      = 1'b1;
                  w_state_next = RX_HDR;
               end
            end else if (r_offset == OFF_DRAIN - 6'd1)
               w_state_next = RX_DRAIN;
         end
         RX_DRAIN: if (w_beat && rx_axis_tlast) begin
            w_exec       = 1'b1;
            w_state_next = EXEC;
         end
         EXEC: begin
            w_start      = 1'b1;
            w_state_next = TX;
         end
         TX:   if (w_tx_done) w_state_next = RX_HDR;
         DROP: if (w_beat && rx_axis_tlast) w_state_next = RX_HDR;
         default: w_state_next = RX_HDR;
      endcase
   end

   always_ff @(posedge gtx_clk_bufg or posedge gtx_reset) begin
      if (gtx_reset) begin
         r_state       <= RX_HDR;
         r_offset      <= '0;
         r_match_fpga  <= 1'b0;
         r_match_bcast <= 1'b0;
         r_src         <= '0;
         r_id          <= '0;
         r_opcode      <= '0;
         r_addr        <= '0;
         r_data        <= '0;
         r_status      <= STATUS_OK;
         r_reply_data  <= '0;
         r_frame_error <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_frame_error <= w_trunc;
         if (w_beat) begin
            if (rx_axis_tlast)
               r_offset <= '0;
            else if (r_offset != 6'd63)
               r_offset <= r_offset + 6'd1;
            if (r_offset <= 6'd5) begin
               r_match_fpga  <= w_m_fpga;
               r_match_bcast <= w_m_bcast;
            end
            if (r_offset >= 6'd6 && r_offset < 6'd12)
               r_src <= {r_src[39:0], rx_axis_tdata};
            if (r_offset == OFF_ID)
               r_id <= rx_axis_tdata;
            if (r_offset >= OFF_OPCODE && r_offset < OFF_ADDR)
               r_opcode <= {r_opcode[23:0], rx_axis_tdata};
            if (r_offset >= OFF_ADDR && r_offset < OFF_DATA)
               r_addr <= {rx_axis_tdata, r_addr[31:8]};
            if (r_offset >= OFF_DATA && r_offset < OFF_DRAIN)
               r_data <= {rx_axis_tdata, r_data[31:8]};
         end
         if (w_exec) begin
            r_status     <= w_cmd_ok ? STATUS_OK : STATUS_ERR;
            r_reply_data <= !w_cmd_ok ? 32'd0 : (w_op_wr ? w_data_eff : w_rd_val);
         end
      end
   end

   always_ff @(posedge gtx_clk_bufg or posedge gtx_reset) begin
      if (gtx_reset) begin
         for (int i = 0; i < 8; i++) begin
            r_ctrl[i] <= '0;
            r_fmc[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (w_wr_ctrl[i]) r_ctrl[i] <= w_data_eff;
            if (w_wr_fmc[i])  r_fmc[i]  <= w_data_eff;
         end
      end
   end

   assign gpio_led    = r_ctrl[0][7:0];
   assign frame_error = r_frame_error;

   cmd_reply_tx u_reply_tx (
      .i_clk     (gtx_clk_bufg),
      .i_rst     (gtx_reset),
      .i_start   (w_start),
      .i_dst_mac (r_src),
      .i_src_mac (FPGA_MAC_ADDR),
      .i_id      (r_id),
      .i_status  (r_status),
      .i_opcode  (r_opcode),
      .i_addr    (r_addr),
      .i_data    (r_reply_data),
      .o_tdata   (tx_axis_tdata),
      .o_tvalid  (tx_axis_tvalid),
      .o_tlast   (tx_axis_tlast),
      .i_tready  (tx_axis_tready),
      .o_done    (w_tx_done)
   );

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed-vector bench for cmd_decoder: builds request frames, captures reply
// bytes and compares them against hand-derived reply images.
module tb_cmd_decoder;

   localparam logic [47:0] FPGA_MAC = 48'h5a0102030405;
   localparam logic [47:0] SRC_MAC  = 48'h02aabbccddee;
   localparam logic [31:0] OP_CCWW  = 32'h43435757;
   localparam logic [31:0] OP_CCRR  = 32'h43435252;
   localparam logic [31:0] OP_FFWW  = 32'h46465757;
   localparam logic [31:0] OP_FFRR  = 32'h46465252;
   localparam logic [31:0] OP_XXWW  = 32'h58585757;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] dip_sw;
   logic [7:0] led;
   logic [7:0] rx_data;
   logic       rx_valid, rx_last, rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid, tx_last, tx_ready;
   logic       frame_error;

   int n_checks = 0;
   int n_errors = 0;
   int fe_count = 0;

   logic [8:0] reply_q[$];
   logic [7:0] req_q[$];
   logic [7:0] exp_q[$];

   always #4 clk = ~clk;

   cmd_decoder #(.FPGA_MAC_ADDR(FPGA_MAC)) dut (
      .gtx_clk_bufg   (clk),
      .gtx_reset      (rst),
      .gpio_dip_sw    (dip_sw),
      .gpio_led       (led),
      .rx_axis_tdata  (rx_data),
      .rx_axis_tvalid (rx_valid),
      .rx_axis_tlast  (rx_last),
      .rx_axis_tready (rx_ready),
      .tx_axis_tdata  (tx_data),
      .tx_axis_tvalid (tx_valid),
      .tx_axis_tlast  (tx_last),
      .tx_axis_tready (tx_ready),
      .frame_error    (frame_error)
   );

   always @(posedge clk) begin
      if (tx_valid && tx_ready) reply_q.push_back({tx_last, tx_data});
      if (frame_error) fe_count <= fe_count + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic build_req(input logic [47:0] dst, input logic [7:0] id, input logic [31:0] op,
                            input logic [31:0] addr, input logic [31:0] data, input int len);
      logic [7:0] full[$];
      for (int k = 5; k >= 0; k--) full.push_back(dst[8*k +: 8]);
      for (int k = 5; k >= 0; k--) full.push_back(SRC_MAC[8*k +: 8]);
      full.push_back(8'h00);
      full.push_back(8'h1c);
      full.push_back(id);
      full.push_back(8'h00);
      for (int k = 3; k >= 0; k--) full.push_back(op[8*k +: 8]);
      for (int k = 0; k < 4; k++) full.push_back(addr[8*k +: 8]);
      for (int k = 0; k < 4; k++) full.push_back(data[8*k +: 8]);
      while (full.size() < len) full.push_back(8'h00);
      req_q.delete();
      for (int k = 0; k < len; k++) req_q.push_back(full[k]);
   endtask

   task automatic send_frame(input bit with_tlast, output int stalls);
      stalls = 0;
      for (int i = 0; i < req_q.size(); i++) begin
         @(negedge clk);
         rx_data  = req_q[i];
         rx_valid = 1'b1;
         rx_last  = with_tlast && (i == req_q.size() - 1);
         for (int g = 0; g < 300 && !rx_ready; g++) begin
            stalls++;
            @(negedge clk);
         end
      end
      @(negedge clk);
      rx_valid = 1'b0;
      rx_last  = 1'b0;
   endtask

   task automatic wait_reply();
      for (int g = 0; g < 400 && reply_q.size() < 60; g++) @(negedge clk);
      repeat (4) @(negedge clk);
   endtask

   task automatic compare_reply(input string tag, input logic [7:0] id, input logic [7:0] st,
                                input logic [31:0] op, input logic [31:0] addr, input logic [31:0] data);
      int bad;
      logic [8:0] e;
      bad = 0;
      exp_q.delete();
      for (int k = 5; k >= 0; k--) exp_q.push_back(SRC_MAC[8*k +: 8]);
      for (int k = 5; k >= 0; k--) exp_q.push_back(FPGA_MAC[8*k +: 8]);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h0e);
      exp_q.push_back(id);
      exp_q.push_back(st);
      for (int k = 3; k >= 0; k--) exp_q.push_back(op[8*k +: 8]);
      for (int k = 0; k < 4; k++) exp_q.push_back(addr[8*k +: 8]);
      for (int k = 0; k < 4; k++) exp_q.push_back(data[8*k +: 8]);
      while (exp_q.size() < 60) exp_q.push_back(8'h00);
      check({tag, "_len"}, reply_q.size(), 60);
      for (int i = 0; i < reply_q.size() && i < 60; i++) begin
         e = {i == 59, exp_q[i]};
         if (reply_q[i] !== e) bad++;
      end
      check({tag, "_bytes"}, bad, 0);
      if (reply_q.size() >= 28) begin
         check({tag, "_status"}, reply_q[15][7:0], st);
         check({tag, "_data"}, {reply_q[27][7:0], reply_q[26][7:0], reply_q[25][7:0], reply_q[24][7:0]}, data);
      end
      $display("txn %s: id=0x%02h op=0x%08h addr=%0d reply_bytes=%0d mismatched=%0d",
               tag, id, op, addr, reply_q.size(), bad);
   endtask

   task automatic do_cmd(input string tag, input logic [47:0] dst, input logic [7:0] id,
                         input logic [31:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input int len, input logic [7:0] exp_st, input logic [31:0] exp_data);
      int stalls;
      reply_q.delete();
      build_req(dst, id, op, addr, data, len);
      send_frame(1'b1, stalls);
      wait_reply();
      compare_reply(tag, id, exp_st, op, addr, exp_data);
   endtask

   initial begin
      int stalls;
      int bad_hold;
      int bad_rdy;
      int q_before;
      logic [7:0] held;

      rst      = 1'b1;
      dip_sw   = 8'h3c;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      rx_last  = 1'b0;
      tx_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_rx_ready", rx_ready, 1);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_last", tx_last, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_frame_error", frame_error, 0);
      check("rst_led", led, 0);
      rst = 1'b0;
      @(negedge clk);

      // Minimum-length CTRL write: tlast on byte 27, timing of led and first reply byte.
      reply_q.delete();
      build_req(FPGA_MAC, 8'h05, OP_CCWW, 32'd0, 32'h000000a5, 28);
      send_frame(1'b1, stalls);
      check("ccww_led", led, 8'ha5);
      check("ccww_rx_ready_low", rx_ready, 0);
      check("ccww_tx_valid_early", tx_valid, 0);
      @(negedge clk);
      check("ccww_tx_valid", tx_valid, 1);
      check("ccww_first_byte", tx_data, SRC_MAC[47:40]);
      wait_reply();
      compare_reply("ccww", 8'h05, 8'h00, OP_CCWW, 32'd0, 32'h000000a5);
      check("ccww_rx_ready_back", rx_ready, 1);

      // FMC write then read; the read's data field must not modify the register.
      do_cmd("ffww", FPGA_MAC, 8'h11, OP_FFWW, 32'd4, 32'h0000001e, 60, 8'h00, 32'h0000001e);
      do_cmd("ffrr", FPGA_MAC, 8'h12, OP_FFRR, 32'd4, 32'hfeedbeef, 60, 8'h00, 32'h0000001e);
      do_cmd("ffrr2", FPGA_MAC, 8'h13, OP_FFRR, 32'd4, 32'h0, 64, 8'h00, 32'h0000001e);

      // Wrong destination MAC: silently dropped.
      reply_q.delete();
      build_req(48'h5a0102030406, 8'h20, OP_CCWW, 32'd0, 32'h00000033, 60);
      send_frame(1'b1, stalls);
      repeat (100) @(negedge clk);
      check("drop_rdy_stalls", stalls, 0);
      check("drop_no_reply", reply_q.size(), 0);
      check("drop_led", led, 8'ha5);
      $display("txn drop: stalls=%0d reply_bytes=%0d led=0x%02h", stalls, reply_q.size(), led);

      // Broadcast destination is accepted.
      do_cmd("bcast_ccrr", 48'hffffffffffff, 8'h21, OP_CCRR, 32'd0, 32'h0, 60, 8'h00, 32'h000000a5);

      // Invalid opcode and out-of-range address.
      do_cmd("xxww", FPGA_MAC, 8'h30, OP_XXWW, 32'd0, 32'h00000077, 60, 8'h01, 32'h0);
      check("xxww_led", led, 8'ha5);
      do_cmd("ccrr_a9", FPGA_MAC, 8'h31, OP_CCRR, 32'd9, 32'h0, 60, 8'h01, 32'h0);
      do_cmd("ccrr_a0", FPGA_MAC, 8'h32, OP_CCRR, 32'd0, 32'h0, 60, 8'h00, 32'h000000a5);

      // Frame truncated at byte 20, then a normal frame.
      reply_q.delete();
      fe_count = 0;
      build_req(FPGA_MAC, 8'h40, OP_CCWW, 32'd1, 32'h0badf00d, 21);
      send_frame(1'b1, stalls);
      repeat (80) @(negedge clk);
      check("trunc_fe_pulses", fe_count, 1);
      check("trunc_no_reply", reply_q.size(), 0);
      $display("txn trunc: frame_error_pulses=%0d reply_bytes=%0d", fe_count, reply_q.size());
      do_cmd("after_trunc_ww", FPGA_MAC, 8'h41, OP_CCWW, 32'd1, 32'h12345678, 60, 8'h00, 32'h12345678);
      do_cmd("after_trunc_rr", FPGA_MAC, 8'h42, OP_CCRR, 32'd1, 32'h0, 60, 8'h00, 32'h12345678);

      // CTRL reg 7 is the read-only DIP switch view.
      do_cmd("dip_rr", FPGA_MAC, 8'h50, OP_CCRR, 32'd7, 32'h0, 60, 8'h00, 32'h0000003c);
      do_cmd("dip_ww", FPGA_MAC, 8'h51, OP_CCWW, 32'd7, 32'h00000099, 60, 8'h00, 32'h00000099);
      do_cmd("dip_rr2", FPGA_MAC, 8'h52, OP_CCRR, 32'd7, 32'h0, 60, 8'h00, 32'h0000003c);

      // Back-pressure on the reply for 32 cycles.
      reply_q.delete();
      build_req(FPGA_MAC, 8'h60, OP_CCRR, 32'd0, 32'h0, 60);
      send_frame(1'b1, stalls);
      repeat (4) @(negedge clk);
      tx_ready = 1'b0;
      @(negedge clk);
      held     = tx_data;
      q_before = reply_q.size();
      bad_hold = 0;
      bad_rdy  = 0;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         if (tx_data !== held || tx_valid !== 1'b1) bad_hold++;
         if (rx_ready !== 1'b0) bad_rdy++;
      end
      check("bp_hold", bad_hold, 0);
      check("bp_rx_ready", bad_rdy, 0);
      check("bp_no_xfer", reply_q.size(), q_before);
      tx_ready = 1'b1;
      wait_reply();
      compare_reply("bp_ccrr", 8'h60, 8'h00, OP_CCRR, 32'd0, 32'h000000a5);

      // Reset in the middle of a frame, then a fresh frame from offset 0.
      reply_q.delete();
      build_req(FPGA_MAC, 8'h70, OP_CCWW, 32'd0, 32'h000000ee, 10);
      send_frame(1'b0, stalls);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_led", led, 0);
      check("midrst_rx_ready", rx_ready, 1);
      do_cmd("midrst_ww", FPGA_MAC, 8'h71, OP_CCWW, 32'd0, 32'h0000005a, 60, 8'h00, 32'h0000005a);
      check("midrst_led_after", led, 8'h5a);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cmd_decoder.md
# cmd_decoder

Ethernet command decoder for the GPR control path. It sits between the MAC's 8-bit receive and transmit AXI-Stream interfaces. It parses host command frames addressed to the FPGA, executes register reads and writes on two small internal register banks, and returns a fixed-format reply frame to the sender.

## Interface
- `FPGA_MAC_ADDR`, default 48'h5a0102030405: destination MAC that this block accepts.
- `gtx_clk_bufg` in 1: the single clock for the whole block.
- `gtx_reset` in 1: asynchronous, active-high reset.
- `gpio_dip_sw` in 8: DIP switch levels, exposed as a read-only register.
- `gpio_led` out 8: equals CTRL bank reg 0 bits [7:0].
- `rx_axis_tdata` in 8, `rx_axis_tvalid` in 1, `rx_axis_tlast` in 1, `rx_axis_tready` out 1: received frame stream, first byte is the destination MAC MSB.
- `tx_axis_tdata` out 8, `tx_axis_tvalid` out 1, `tx_axis_tlast` out 1, `tx_axis_tready` in 1: reply frame stream.
- `frame_error` out 1: one-cycle pulse when a frame is truncated.

## Operation
- A beat transfers when tvalid && tready. Byte offsets count from 0 at the first beat after tlast or reset.
- Request layout:
  - bytes 0-5: destination MAC.
  - bytes 6-11: source MAC, latched.
  - bytes 12-13: length, ignored.
  - byte 14: command id.
  - byte 15: reserved.
  - bytes 16-19: opcode, ASCII.
  - bytes 20-23: address, little-endian.
  - bytes 24-27: data, little-endian.
  - Bytes from 28 up to tlast are consumed and ignored.
- Opcode bytes 16-17 select the bank: "CC" (0x4343) = CTRL, "FF" (0x4646) = FMC.
- Opcode bytes 18-19 select the operation: "WW" (0x5757) = write, "RR" (0x5252) = read.
- Any other opcode is invalid.
- Each bank holds 8 registers × 32 bits, all reset to 0. Valid addresses are 0-7.
- CTRL reg 7 is read-only and reads {24'b0, gpio_dip_sw}; writes to it are ignored but still acknowledged.
- Destination MAC mismatch (not FPGA_MAC_ADDR and not ff:ff:ff:ff:ff:ff): the frame is silently discarded to tlast, with no reply.
- tlast before byte 27: the frame is discarded, `frame_error` pulses, no reply.
- Execution happens when the tlast beat is accepted:
  - A valid write updates the register.
  - A valid read samples the register.
  - An invalid opcode or an address > 7 sets status 0x01 and changes no register.
  - Otherwise status is 0x00.
- Reply frame, always 60 bytes:
  - bytes 0-5: request source MAC.
  - bytes 6-11: FPGA_MAC_ADDR.
  - bytes 12-13: 0x000e.
  - byte 14: echoed id.
  - byte 15: status.
  - bytes 16-19: echoed opcode.
  - bytes 20-23: echoed address, little-endian.
  - bytes 24-27: data, little-endian. A read returns the register value, a write returns the written value, an error returns 0.
  - bytes 28-59: zeros.
  - tlast is asserted on byte 59.
- State machine:
  - RX_HDR → RX_CMD → RX_DRAIN → EXEC → TX → RX_HDR.
  - A rejected frame goes to DROP, which returns to RX_HDR after tlast.
  - A frame that is not a command frame never enters EXEC.

## Timing
- Reset values:
  - `rx_axis_tready` = 1.
  - `tx_axis_tvalid` = 0, `tx_axis_tlast` = 0, `tx_axis_tdata` = 0.
  - `frame_error` = 0, `gpio_led` = 0.
  - All registers = 0; state = RX_HDR.
- `rx_axis_tready` is 1 in RX_HDR, RX_CMD, RX_DRAIN and DROP.
- `rx_axis_tready` is 0 from the cycle after the command tlast is accepted until the reply's last byte is accepted.
- A register write is visible on `gpio_led` 1 cycle after the tlast beat.
- The first reply byte is valid 2 cycles after the tlast beat.
- TX holds tdata and tvalid stable while tready is 0. Each byte advances only on tvalid && tready.
- Reset asserted mid-frame or mid-reply aborts the transfer immediately. The next received byte is treated as offset 0.

## Structure
- The shared package holds:
  - opcode constants CC, FF, WW, RR;
  - frame offsets 14, 16, 20, 24, 28;
  - reply length 60 and reply header length 0x000e;
  - status codes 0x00 and 0x01.
- One sub-module, `cmd_reply_tx`: a 60-byte reply serializer with a start pulse and field inputs.

## Test plan
- Frame to 5a0102030405, "CCWW", id 0x05, addr 0, data 0x000000a5:
  - `gpio_led` = 0xa5.
  - Reply: dst = request source, status 0x00, data bytes a5 00 00 00, 60 bytes, tlast on byte 59.
- "FFWW" to addr 4 with data 0x0000001e, then "FFRR" to addr 4 with data 0xfeedbeef:
  - Read reply data = 0x0000001e.
  - FMC reg 4 unchanged by the read.
- Frame with destination 5a0102030406, carrying a CTRL write:
  - No reply; `gpio_led` unchanged; tready stays 1 through tlast.
- Opcode "XXWW", and separately "CCRR" with addr 9:
  - Reply status 0x01, data 0; no register changes.
- Frame ending at byte 20:
  - `frame_error` pulses once; no reply.
  - The next valid frame is processed normally.
- Hold `tx_axis_tready` at 0 for 32 cycles during a reply:
  - Byte held stable; `rx_axis_tready` = 0; no data lost once tready returns.
